// File: rtl/sync_peak_search_pkg.sv
// Shared synchroniser definitions: peak-search FSM encoding and default datapath widths
// used by the correlator, peak search and FFT-window logic.
package sync_peak_search_pkg;

    localparam int SYNC_MAG_WIDTH        = 11;
    localparam int SYNC_GP_COUNTER_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } peak_state_t;

endpackage

// File: rtl/sync_peak_search_cmp.sv
// Combinational qualify/compare unit for the peak search: threshold test, tie rule and,
// with SYNC_PEAK_SECOND_EN defined, the runner-up compare.
module sync_peak_cmp
    import sync_peak_search_pkg::*;
#(
    parameter int MAG_WIDTH = SYNC_MAG_WIDTH,
    parameter bit TIE_LAST  = 1'b0
) (
    input  logic [MAG_WIDTH-1:0] i_mag,
    input  logic [MAG_WIDTH-1:0] i_threshold,
    input  logic [MAG_WIDTH-1:0] i_peak_mag,
    input  logic                 i_peak_valid,
`ifdef SYNC_PEAK_SECOND_EN
    input  logic [MAG_WIDTH-1:0] i_peak_mag2,
    output logic                 o_new_second,
`endif
    output logic                 o_new_peak
);

    logic w_meets;
    logic w_beats;

    always_comb begin
        w_meets    = (i_mag >= i_threshold);
        w_beats    = TIE_LAST ? (i_mag >= i_peak_mag) : (i_mag > i_peak_mag);
        o_new_peak = w_meets && (!i_peak_valid || w_beats);
`ifdef SYNC_PEAK_SECOND_EN
        // Runner-up only considered when the sample does not displace the primary peak.
        o_new_second = w_meets && !o_new_peak && (i_mag > i_peak_mag2) &&
                       (TIE_LAST ? (i_mag <= i_peak_mag) : (i_mag < i_peak_mag));
`endif
    end

endmodule

// File: rtl/sync_peak_search.sv
// Windowed max-magnitude search with threshold qualification for long-preamble timing.
// Optional second-peak tracking is enabled by defining SYNC_PEAK_SECOND_EN.
module sync_peak_search
    import sync_peak_search_pkg::*;
#(
    parameter int MAG_WIDTH        = SYNC_MAG_WIDTH,
    parameter int GP_COUNTER_WIDTH = SYNC_GP_COUNTER_WIDTH,
    parameter bit TIE_LAST         = 1'b0
) (
    input  logic                        CLK,
    input  logic                        s_RST,
    input  logic                        enable,
    input  logic                        start,
    input  logic [GP_COUNTER_WIDTH-1:0] win_len,
    input  logic [MAG_WIDTH-1:0]        threshold,
    input  logic [MAG_WIDTH-1:0]        Mag_Val,
    input  logic                        input_strobe,
    output logic [GP_COUNTER_WIDTH-1:0] Index,
    output logic [MAG_WIDTH-1:0]        Peak_Mag,
    output logic                        peak_valid,
    output logic                        done,
`ifdef SYNC_PEAK_SECOND_EN
    output logic [GP_COUNTER_WIDTH-1:0] Index2,
    output logic [MAG_WIDTH-1:0]        Peak_Mag2,
`endif
    output logic                        busy
);

    localparam logic [GP_COUNTER_WIDTH-1:0] CNT_ONE = GP_COUNTER_WIDTH'(1);

    peak_state_t                 r_state;
    peak_state_t                 w_state_next;
    logic [GP_COUNTER_WIDTH-1:0] r_win_len;
    logic [MAG_WIDTH-1:0]        r_threshold;
    logic [GP_COUNTER_WIDTH-1:0] r_count;
    logic [GP_COUNTER_WIDTH-1:0] r_index;
    logic [MAG_WIDTH-1:0]        r_peak_mag;
    logic                        r_peak_valid;
    logic                        r_done;
    logic                        w_new_peak;
    logic                        w_last;
`ifdef SYNC_PEAK_SECOND_EN
    logic [GP_COUNTER_WIDTH-1:0] r_index2;
    logic [MAG_WIDTH-1:0]        r_peak_mag2;
    logic                        w_new_second;
`endif

    sync_peak_cmp #(
        .MAG_WIDTH (MAG_WIDTH),
        .TIE_LAST  (TIE_LAST)
    ) u_cmp (
        .i_mag        (Mag_Val),
        .i_threshold  (r_threshold),
        .i_peak_mag   (r_peak_mag),
        .i_peak_valid (r_peak_valid),
`ifdef SYNC_PEAK_SECOND_EN
        .i_peak_mag2  (r_peak_mag2),
        .o_new_second (w_new_second),
`endif
        .o_new_peak   (w_new_peak)
    );

    // win_len of 0 wraps to all-ones, giving a full 2^GP_COUNTER_WIDTH window.
    assign w_last = (r_count == (r_win_len - CNT_ONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_next = ST_SEARCH;
            ST_SEARCH:        if (!start && input_strobe && w_last) w_state_next = ST_DONE;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (s_RST || !enable) begin
            r_state      <= ST_IDLE;
            r_win_len    <= '0;
            r_threshold  <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_peak_mag   <= '0;
            r_peak_valid <= 1'b0;
            r_done       <= 1'b0;
`ifdef SYNC_PEAK_SECOND_EN
            r_index2     <= '0;
            r_peak_mag2  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_SEARCH) && (w_state_next == ST_DONE);
            // start always wins: it arms or restarts the window and drops any coincident strobe.
            if (start) begin
                r_win_len    <= win_len;
                r_threshold  <= threshold;
                r_count      <= '0;
                r_index      <= '0;
                r_peak_mag   <= '0;
                r_peak_valid <= 1'b0;
`ifdef SYNC_PEAK_SECOND_EN
                r_index2     <= '0;
                r_peak_mag2  <= '0;
`endif
            end else if ((r_state == ST_SEARCH) && input_strobe) begin
                r_count <= r_count + CNT_ONE;
                if (w_new_peak) begin
                    r_peak_mag   <= Mag_Val;
                    r_index      <= r_count;
                    r_peak_valid <= 1'b1;
`ifdef SYNC_PEAK_SECOND_EN
                    r_peak_mag2  <= r_peak_mag;
                    r_index2     <= r_index;
`endif
                end
`ifdef SYNC_PEAK_SECOND_EN
                else if (w_new_second) begin
                    r_peak_mag2 <= Mag_Val;
                    r_index2    <= r_count;
                end
`endif
            end
        end
    end

    assign Index      = r_index;
    assign Peak_Mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
    assign done       = r_done;
    assign busy       = (r_state == ST_SEARCH);
`ifdef SYNC_PEAK_SECOND_EN
    assign Index2     = r_index2;
    assign Peak_Mag2  = r_peak_mag2;
`endif

endmodule

// File: doc/sync_peak_search.md
Name: sync_peak_search

Overview:
Windowed maximum-magnitude search for the long-preamble timing stage of the synchroniser. It scans a programmable number of strobed correlator magnitudes and qualifies the peak against a threshold. It reports the peak's magnitude and sample index with a one-cycle done pulse. It sits between the correlator magnitude stage and the symbol-timing/FFT-window logic.

Parameters:
MAG_WIDTH, 11, width of input magnitude and stored peak
GP_COUNTER_WIDTH, 8, width of sample index, window length and counter
TIE_LAST, 0, 0: earliest of equal maxima wins; 1: latest of equal maxima wins

Ports:
CLK  in  1  clock; single clock domain
s_RST  in  1  reset; synchronous, active-high
enable  in  1  block enable; low = synchronous clear to IDLE
start  in  1  one-cycle pulse that arms a new search window
win_len  in  GP_COUNTER_WIDTH  samples per window; 0 means 2^GP_COUNTER_WIDTH; sampled on start
threshold  in  MAG_WIDTH  minimum qualifying magnitude; sampled on start
Mag_Val  in  MAG_WIDTH  unsigned magnitude sample
input_strobe  in  1  Mag_Val valid this cycle
Index  out  GP_COUNTER_WIDTH  window-relative index of the peak
Peak_Mag  out  MAG_WIDTH  magnitude of the peak
peak_valid  out  1  at least one sample met threshold; valid while done or in DONE
done  out  1  one-cycle pulse when the window completes
busy  out  1  high in SEARCH

Behaviour:
- Reset (s_RST=1) or enable=0 (s_RST has priority):
  - state←IDLE.
  - Index, Peak_Mag, peak_valid, done, busy, sample counter and latched win_len/threshold all ←0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 latches win_len and threshold, clears counter/Index/Peak_Mag/peak_valid, then moves to SEARCH.
  - Strobes are ignored in IDLE, including a strobe in the same cycle as start.
- SEARCH, busy=1, on each input_strobe:
  - A sample qualifies if Mag_Val ≥ threshold_latched, and either peak_valid=0 or Mag_Val > Peak_Mag (TIE_LAST=1: ≥).
  - On qualify: Peak_Mag←Mag_Val, Index←counter, peak_valid←1.
  - Counter increments and wraps modulo 2^GP_COUNTER_WIDTH.
  - No strobe: no state change.
- Window end:
  - The strobe with counter == win_len_latched−1 (wrap-aware; for 0 that is all-ones) is compared normally.
  - The FSM then moves to DONE.
  - done=1 in the first DONE cycle only. Index/Peak_Mag/peak_valid are final in that cycle.
  - Latency: done is one cycle after the clock edge that captured the last strobe.
- DONE:
  - Outputs hold until the next start. start moves directly to SEARCH, same as in IDLE.
  - done never stays high for more than one cycle.
- start while in SEARCH: restarts the window (re-latch, clear, counter←0); the current strobe is discarded; no done pulse.
- No sample meets threshold: done still pulses; peak_valid=0, Peak_Mag=0, Index=0.
- Threshold 0: every sample qualifies, which matches plain max-search.
- Comparison is unsigned and full-width; no saturation is needed.

Optional Feature:
Macro SYNC_PEAK_SECOND_EN.
- Defined:
  - Adds outputs Index2 [GP_COUNTER_WIDTH] and Peak_Mag2 [MAG_WIDTH], holding the second-largest qualifying sample.
  - When a new peak is stored, the old peak moves to the second-peak registers.
  - Otherwise a qualifying sample with Mag_Val > Peak_Mag2 and Mag_Val ≤ Peak_Mag (below Peak_Mag when TIE_LAST=0) replaces the second peak.
  - Cleared with the primary registers; valid in DONE.
- Not defined: the ports and logic are absent, and primary behaviour is identical.

Decomposition:
- Shared sync package holds:
  - FSM state encoding localparams (IDLE=2'd0, SEARCH=2'd1, DONE=2'd2);
  - default MAG_WIDTH/GP_COUNTER_WIDTH constants shared with the correlator and the FFT-window logic.
- One natural sub-module: sync_peak_cmp, a combinational qualify/compare unit (threshold, tie rule, second-peak compare) instantiated once.

Test Plan:
1. win_len=4, threshold=0, strobes 5,9,3,7 → done one cycle after 4th strobe; Index=1, Peak_Mag=9, peak_valid=1.
2. TIE_LAST=0, win_len=3, samples 6,6,2 → Index=0; TIE_LAST=1 → Index=1.
3. threshold=100, win_len=4, samples 20,50,90,10 → done pulses; peak_valid=0, Peak_Mag=0, Index=0.
4. win_len=8, gaps between strobes, start re-pulsed after 3rd strobe, then 8 strobes max 40 at 6th → no done before restart; Index=5, Peak_Mag=40.
5. enable dropped mid-SEARCH after 2 strobes → next cycle busy=0 and all outputs 0; strobes ignored until a new start.
6. SYNC_PEAK_SECOND_EN, win_len=5, samples 10,30,20,25,5 → Peak_Mag=30/Index=1, Peak_Mag2=25/Index2=3; GP_COUNTER_WIDTH=4, win_len=0 → done after 16 strobes.
